// File: rtl/pwm_deadband.sv
// Complementary PWM driver with programmable dead time between the high-side
// and low-side gate drives, plus an optional latched fault input.
// Build option: define PWM_DB_TRIP_EN to include the trip/trip_clr fault latch;
// without it the trip inputs are ignored and tripped stays 0.
module pwm_deadband #(
    parameter int unsigned DB_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            pwm_in,
    input  logic [DB_W-1:0] db_rise,
    input  logic [DB_W-1:0] db_fall,
    input  logic            trip,
    input  logic            trip_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            db_active,
    output logic            tripped
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOW_ON  = 3'd1,
        S_DT_RISE = 3'd2,
        S_HIGH_ON = 3'd3,
        S_DT_FALL = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            pwm_in_q;
    logic            pwm_h_q, pwm_h_d;
    logic            pwm_l_q, pwm_l_d;
    logic            db_active_q, db_active_d;
    logic            fault_c;

`ifdef PWM_DB_TRIP_EN
    logic tripped_q, tripped_d;

    // Fault latch: set by trip, cleared only by trip_clr while trip is low.
    always_comb begin
        tripped_d = tripped_q;
        if (trip) begin
            tripped_d = 1'b1;
        end else if (trip_clr) begin
            tripped_d = 1'b0;
        end
    end

    // Fault flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tripped_q <= 1'b0;
        end else begin
            tripped_q <= tripped_d;
        end
    end

    assign fault_c = trip | tripped_q;
    assign tripped = tripped_q;
`else
    logic unused_trip;

    assign unused_trip = trip ^ trip_clr;
    assign fault_c     = 1'b0;
    assign tripped     = 1'b0;
`endif

    // Single-stage input register; the FSM only looks at the registered copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_in_q <= 1'b0;
        end else begin
            pwm_in_q <= pwm_in;
        end
    end

    // State and dead-time counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; fault beats enable, enable beats the PWM input.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (fault_c || !enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Outputs are already off, so the high side still gets
                    // a full dead-time window loaded from db_rise.
                    if (pwm_in_q) begin
                        state_d = S_DT_RISE;
                        cnt_d   = db_rise;
                    end else begin
                        state_d = S_LOW_ON;
                    end
                end
                S_LOW_ON: begin
                    if (pwm_in_q) begin
                        if (db_rise == '0) begin
                            state_d = S_HIGH_ON;
                        end else begin
                            state_d = S_DT_RISE;
                            cnt_d   = db_rise;
                        end
                    end
                end
                S_DT_RISE: begin
                    // A pulse shorter than the dead time is swallowed.
                    if (!pwm_in_q) begin
                        state_d = S_LOW_ON;
                        cnt_d   = '0;
                    end else if (cnt_q <= DB_W'(1)) begin
                        state_d = S_HIGH_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DB_W'(1);
                    end
                end
                S_HIGH_ON: begin
                    if (!pwm_in_q) begin
                        if (db_fall == '0) begin
                            state_d = S_LOW_ON;
                        end else begin
                            state_d = S_DT_FALL;
                            cnt_d   = db_fall;
                        end
                    end
                end
                S_DT_FALL: begin
                    if (pwm_in_q) begin
                        state_d = S_HIGH_ON;
                        cnt_d   = '0;
                    end else if (cnt_q <= DB_W'(1)) begin
                        state_d = S_LOW_ON;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - DB_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move on the same edge.
    always_comb begin
        pwm_h_d     = 1'b0;
        pwm_l_d     = 1'b0;
        db_active_d = 1'b0;
        case (state_d)
            S_LOW_ON:  pwm_l_d     = 1'b1;
            S_HIGH_ON: pwm_h_d     = 1'b1;
            S_DT_RISE: db_active_d = 1'b1;
            S_DT_FALL: db_active_d = 1'b1;
            default: begin
                pwm_h_d     = 1'b0;
                pwm_l_d     = 1'b0;
                db_active_d = 1'b0;
            end
        endcase
    end

    // Registered gate drives and dead-time flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_h_q     <= 1'b0;
            pwm_l_q     <= 1'b0;
            db_active_q <= 1'b0;
        end else begin
            pwm_h_q     <= pwm_h_d;
            pwm_l_q     <= pwm_l_d;
            db_active_q <= db_active_d;
        end
    end

    assign pwm_h     = pwm_h_q;
    assign pwm_l     = pwm_l_q;
    assign db_active = db_active_q;

endmodule

// File: tb/tb_pwm_deadband.sv
// Directed bench for pwm_deadband: dead-time length and latency, short pulse
// suppression, zero dead time, mid-dead-time reprogramming, enable, reset
// and (when PWM_DB_TRIP_EN is defined) the fault latch.
module tb_pwm_deadband;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       pwm_in;
    logic [7:0] db_rise;
    logic [7:0] db_fall;
    logic       trip;
    logic       trip_clr;
    logic       pwm_h;
    logic       pwm_l;
    logic       db_active;
    logic       tripped;

    int n_checks = 0;
    int n_pass   = 0;
    int overlap_cnt = 0;

    pwm_deadband #(.DB_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .pwm_in    (pwm_in),
        .db_rise   (db_rise),
        .db_fall   (db_fall),
        .trip      (trip),
        .trip_clr  (trip_clr),
        .pwm_h     (pwm_h),
        .pwm_l     (pwm_l),
        .db_active (db_active),
        .tripped   (tripped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shoot-through watchdog.
    always @(negedge clk) begin
        if (pwm_h && pwm_l) overlap_cnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick until the target side turns on, counting both-off samples.
    task automatic measure(input bit to_high, input int mid_at, input logic [7:0] mid_fall,
                           output int dead, output int ticks, output bit dbok);
        bit done;
        dead  = 0;
        ticks = 0;
        dbok  = 1'b1;
        done  = 1'b0;
        while (!done && ticks < 300) begin
            tick();
            ticks++;
            if (to_high ? pwm_h : pwm_l) begin
                done = 1'b1;
            end else if (!pwm_h && !pwm_l) begin
                dead++;
                if (!db_active) dbok = 1'b0;
                if (dead == mid_at) db_fall = mid_fall;
            end
        end
        if (!done) check("measure_timeout", 0, 1);
    endtask

    initial begin
        int  dead;
        int  ticks;
        bit  dbok;
        int  h_seen;
        int  both_low;
        int  h_cnt;
        int  dba_cnt;

        rst      = 1'b1;
        enable   = 1'b1;
        pwm_in   = 1'b0;
        db_rise  = 8'd20;
        db_fall  = 8'd20;
        trip     = 1'b0;
        trip_clr = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_h", int'(pwm_h), 0);
        check("rst_l", int'(pwm_l), 0);
        check("rst_dba", int'(db_active), 0);
        check("rst_tripped", int'(tripped), 0);
        rst = 1'b0;
        tick();
        check("first_edge_l", int'(pwm_l), 1);
        tick();

        // Rising dead time of 20 with latency k+1+20
        pwm_in = 1'b1;
        measure(1'b1, -1, 8'd0, dead, ticks, dbok);
        check("rise20_dead", dead, 20);
        check("rise20_latency", ticks, 22);
        check("rise20_dba", int'(dbok), 1);

        // Falling dead time of 20
        pwm_in = 1'b0;
        measure(1'b0, -1, 8'd0, dead, ticks, dbok);
        check("fall20_dead", dead, 20);
        check("fall20_latency", ticks, 22);

        // 5-cycle pulse against a 10-cycle dead time is swallowed
        db_rise = 8'd10;
        pwm_in  = 1'b1;
        h_seen  = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pwm_h) h_seen++;
        end
        pwm_in = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (pwm_h) h_seen++;
        end
        check("short_pulse_h", h_seen, 0);
        check("short_pulse_l", int'(pwm_l), 1);

        // Dead time latched at load; reprogramming mid-window has no effect
        db_rise = 8'd4;
        pwm_in  = 1'b1;
        measure(1'b1, -1, 8'd0, dead, ticks, dbok);
        check("rise4_dead", dead, 4);
        db_fall = 8'd15;
        pwm_in  = 1'b0;
        measure(1'b0, 1, 8'd3, dead, ticks, dbok);
        check("fall15_reprog_dead", dead, 15);
        check("fall15_dba", int'(dbok), 1);

        // Zero dead time: direct swaps, h lags pwm_in by two edges
        db_rise  = 8'd0;
        db_fall  = 8'd0;
        both_low = 0;
        h_cnt    = 0;
        dba_cnt  = 0;
        for (int i = 0; i < 24; i++) begin
            pwm_in = ((i / 3) % 2) == 1;
            tick();
            if (!pwm_h && !pwm_l) both_low++;
            if (pwm_h) h_cnt++;
            if (db_active) dba_cnt++;
        end
        check("zero_db_both_low", both_low, 0);
        check("zero_db_h_cnt", h_cnt, 11);
        check("zero_db_dba", dba_cnt, 0);

        // Enable low forces both off; re-enable from idle gets full dead time
        tick();
        check("pre_disable_h", int'(pwm_h), 1);
        enable = 1'b0;
        tick();
        check("disable_h", int'(pwm_h), 0);
        check("disable_l", int'(pwm_l), 0);
        tick();
        tick();
        check("disable_hold_h", int'(pwm_h), 0);
        db_rise = 8'd3;
        enable  = 1'b1;
        measure(1'b1, -1, 8'd0, dead, ticks, dbok);
        check("reenable_dead", dead, 3);
        check("reenable_latency", ticks, 4);

        // Asynchronous reset in the middle of a rising dead time
        pwm_in  = 1'b0;
        db_fall = 8'd2;
        measure(1'b0, -1, 8'd0, dead, ticks, dbok);
        check("fall2_dead", dead, 2);
        db_rise = 8'd8;
        pwm_in  = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("pre_rst_dba", int'(db_active), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_h", int'(pwm_h), 0);
        check("async_rst_l", int'(pwm_l), 0);
        check("async_rst_dba", int'(db_active), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        measure(1'b1, -1, 8'd0, dead, ticks, dbok);
        check("post_rst_dead", dead, 8);
        check("post_rst_latency", ticks, 10);

`ifdef PWM_DB_TRIP_EN
        // Fault latch behaviour from HIGH_ON
        trip = 1'b1;
        tick();
        check("trip_h", int'(pwm_h), 0);
        check("trip_l", int'(pwm_l), 0);
        check("trip_flag", int'(tripped), 1);
        trip = 1'b0;
        tick();
        check("trip_hold", int'(tripped), 1);
        check("trip_hold_h", int'(pwm_h), 0);
        trip     = 1'b1;
        trip_clr = 1'b1;
        tick();
        check("trip_beats_clr", int'(tripped), 1);
        trip = 1'b0;
        tick();
        check("trip_cleared", int'(tripped), 0);
        check("trip_cleared_h", int'(pwm_h), 0);
        trip_clr = 1'b0;
        tick();
        check("post_clr_dba", int'(db_active), 1);
        check("post_clr_h", int'(pwm_h), 0);
`else
        // Trip inputs ignored in the default build
        trip = 1'b1;
        tick();
        check("notrip_h", int'(pwm_h), 1);
        check("notrip_flag", int'(tripped), 0);
        trip     = 1'b0;
        trip_clr = 1'b1;
        tick();
        check("notrip_clr_flag", int'(tripped), 0);
        trip_clr = 1'b0;
`endif

        tick();
        check("no_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
